decode_stage: RTL and testbench

//  Registered, parametrised RV64 instruction decode stage between fetch and issue.

---
 rtl/decode_stage.sv | 138 +++++++++++++
 tb/tb_decode_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV64 decode stage: classifies and field-splits each instruction, builds the
// sign-extended immediate and queues results in a small valid/ready FIFO.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_fmt,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decode_count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        dec;
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;
  logic          push, pop;
  logic          sgn;

  assign sgn = in_instr[31];

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.instr   = in_instr;
    dec.illegal = 1'b0;
    unique case (in_instr[6:0])
      7'b0110011, 7'b0111011: dec.fmt = 3'd0;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        dec.fmt = 3'd1;
        dec.imm = {{(XLEN-12){sgn}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec.fmt = 3'd2;
        dec.imm = {{(XLEN-12){sgn}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = 3'd3;
        dec.imm = {{(XLEN-12){sgn}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = 3'd4;
        dec.imm = {{(XLEN-32){sgn}}, in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = 3'd5;
        dec.imm = {{(XLEN-20){sgn}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      // Covers bad low bits too, since every legal opcode ends in 2'b11.
      default: begin
        dec.fmt     = 3'd7;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // in_ready is registered from the post-edge occupancy, so a full FIFO
  // refuses input even in a cycle where the consumer pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_ready     <= 1'b0;
      decode_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        decode_count <= decode_count + 1'b1;
      end
      count    <= count_next;
      in_ready <= (count_next < (PW+1)'(DEPTH));
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_pc      = head.pc;
  assign out_fmt     = head.fmt;
  assign out_opcode  = head.instr[6:0];
  assign out_funct3  = head.instr[14:12];
  assign out_funct7  = head.instr[31:25];
  assign out_rs1     = head.instr[19:15];
  assign out_rs2     = head.instr[24:20];
  assign out_rd      = head.instr[11:7];
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush,
// reset mid-stream, and decode_count wrap on a narrow-counter instance.
module tb_decode_stage;

  logic        clk;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [2:0]  out_fmt, out_funct3;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] decode_count;

  logic        w_reset, w_flush, w_in_valid, w_out_ready;
  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [31:0] w_in_instr;
  logic [63:0] w_in_pc, w_out_pc, w_out_imm;
  logic [2:0]  w_out_fmt, w_out_funct3;
  logic [6:0]  w_out_opcode, w_out_funct7;
  logic [4:0]  w_out_rs1, w_out_rs2, w_out_rd;
  logic [1:0]  w_decode_count;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.XLEN(64), .DEPTH(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_fmt(out_fmt), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_illegal(out_illegal), .decode_count(decode_count)
  );

  decode_stage #(.XLEN(64), .DEPTH(2), .CNT_W(2)) dut_wrap (
    .clk(clk), .reset(w_reset), .flush(w_flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr), .in_pc(w_in_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc),
    .out_fmt(w_out_fmt), .out_opcode(w_out_opcode), .out_funct3(w_out_funct3),
    .out_funct7(w_out_funct7), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2), .out_rd(w_out_rd),
    .out_imm(w_out_imm), .out_illegal(w_out_illegal), .decode_count(w_decode_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push one instruction with out_ready=1, check the head the cycle after the
  // accept edge, then let the next edge pop it.
  task automatic decode_one(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                            input logic [2:0] fmt, input logic [63:0] imm, input logic ill);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_pc"},    out_pc, pc);
    check({tag, "_fmt"},   64'(out_fmt), 64'(fmt));
    check({tag, "_imm"},   out_imm, imm);
    check({tag, "_ill"},   64'(out_illegal), 64'(ill));
    check({tag, "_op"},    64'(out_opcode), 64'(instr[6:0]));
    step();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    w_reset = 1'b1; w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_in_instr = 32'h002081B3; w_in_pc = 64'h40;
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_count", 64'(decode_count), 64'd0);
    reset = 1'b0;
    w_reset = 1'b0;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    decode_one("add", 32'h002081B3, 64'h1000, 3'd0, 64'd0, 1'b0);
    decode_one("addi", 32'hFFF00293, 64'h1004, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    decode_one("sw", 32'h0020A423, 64'h1008, 3'd2, 64'd8, 1'b0);
    decode_one("beq", 32'hFE000EE3, 64'h100C, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    decode_one("lui", 32'h123450B7, 64'h1010, 3'd4, 64'h0000_0000_1234_5000, 1'b0);
    decode_one("jal", 32'hFF9FF0EF, 64'h1014, 3'd5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    decode_one("zero", 32'h00000000, 64'h1018, 3'd7, 64'd0, 1'b1);
    check("after_dec_count", 64'(decode_count), 64'd7);
    check("after_dec_valid", 64'(out_valid), 64'd0);

    // Register fields of add x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h2000;
    step();
    in_valid = 1'b0;
    check("add_rs1", 64'(out_rs1), 64'd1);
    check("add_rs2", 64'(out_rs2), 64'd2);
    check("add_rd", 64'(out_rd), 64'd3);
    check("add_f3", 64'(out_funct3), 64'd0);
    check("add_f7", 64'(out_funct7), 64'd0);
    step();
    check("fields_count", 64'(decode_count), 64'd8);

    // Backpressure with three pushes into a two-entry FIFO
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h100;
    step();
    check("bp_valid1", 64'(out_valid), 64'd1);
    check("bp_ready1", 64'(in_ready), 64'd1);
    in_instr = 32'hFFF00293; in_pc = 64'h104;
    step();
    check("bp_ready_full", 64'(in_ready), 64'd0);
    in_instr = 32'h123450B7; in_pc = 64'h108;
    step();
    check("bp_hold_pc", out_pc, 64'h100);
    check("bp_hold_fmt", 64'(out_fmt), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_pop1_pc", out_pc, 64'h104);
    check("bp_pop1_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_pushpop_pc", out_pc, 64'h108);
    check("bp_pushpop_fmt", 64'(out_fmt), 64'd4);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_count", 64'(decode_count), 64'd11);

    // Flush with two buffered, a pending input and a would-be pop
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h200;
    step();
    in_pc = 64'h204;
    step();
    in_pc = 64'h208;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_count", 64'(decode_count), 64'd11);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_pc_zero", out_pc, 64'd0);
    in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 64'h300;
    step();
    in_valid = 1'b0;
    check("post_flush_pc", out_pc, 64'h300);
    check("post_flush_fmt", 64'(out_fmt), 64'd2);
    step();
    check("post_flush_count", 64'(decode_count), 64'd12);

    // Reset mid-stream discards buffered entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h400;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_count", 64'(decode_count), 64'd0);
    reset = 1'b0;
    step();
    check("mid_rst_ready_after", 64'(in_ready), 64'd1);

    // decode_count wrap on the 2-bit counter instance
    for (int i = 0; i < 3; i++) begin
      w_in_valid = 1'b1;
      step();
      w_in_valid = 1'b0;
      step();
    end
    check("wrap_pre", 64'(w_decode_count), 64'd3);
    w_in_valid = 1'b1;
    step();
    w_in_valid = 1'b0;
    check("wrap_valid", 64'(w_out_valid), 64'd1);
    step();
    check("wrap_zero", 64'(w_decode_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
